// File: rtl/vp_gfx_bitmap_gen.sv
// Block-graphics cell bitmap generator: turns a packed block word into one
// pixel row per scanline, with solid/separated rendering, inverse and blink.
module vp_gfx_bitmap_gen #(
    parameter int GRID_COLS    = 4,
    parameter int GRID_ROWS    = 5,
    parameter int CHAR_WIDTH   = 16,
    parameter int CHAR_HEIGHT  = 20,
    parameter int ROW_BITS     = 5,
    parameter int BLINK_PERIOD = 32,
    parameter int BLINK_ON     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enabled,
    input  logic [3:0]                     foreground,
    input  logic [3:0]                     background,
    input  logic [GRID_COLS*GRID_ROWS-1:0] gfx_bits,
    input  logic [ROW_BITS-1:0]            char_row,
    input  logic                           mosaic,
    input  logic                           invert,
    input  logic                           blink,
    input  logic                           frame_start,
    output logic [3:0]                     gfx_foreground,
    output logic [3:0]                     gfx_background,
    output logic [CHAR_WIDTH-1:0]          gfx_bitmap,
    output logic                           enable
);
    localparam int BW    = CHAR_WIDTH / GRID_COLS;
    localparam int BH    = CHAR_HEIGHT / GRID_ROWS;
    localparam int NB    = GRID_COLS * GRID_ROWS;
    localparam int BR_W  = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int LN_W  = (BH > 1) ? $clog2(BH) : 1;
    localparam int CNT_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [NB-1:0] ONE_NB = {{(NB-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  phase_off;
    logic                  valid1_q, valid1_d;
    logic [3:0]            fg1_q, fg1_d, bg1_q, bg1_d;
    logic                  blink1_q, blink1_d, invert1_q, invert1_d;
    logic                  mosaic1_q, mosaic1_d, off1_q, off1_d;
    logic [NB-1:0]         bits1_q, bits1_d;
    logic [BR_W-1:0]       br1_q, br1_d;
    logic [LN_W-1:0]       line1_q, line1_d;
    logic                  enable_q, enable_d;
    logic [3:0]            gfx_fg_q, gfx_fg_d, gfx_bg_q, gfx_bg_d;
    logic [CHAR_WIDTH-1:0] bitmap_q, bitmap_d;
    logic [3:0]            fg_sel, bg_sel;
    logic                  pix;
    int                    r_eff;
    int                    bit_idx;

    // Phase seen by a transfer is the count before this cycle's frame_start.
    assign phase_off = (int'(cnt_q) >= BLINK_ON);

    // Frame counter for blink, free-running on frame_start pulses.
    always_comb begin
        cnt_d = cnt_q;
        if (frame_start) begin
            cnt_d = (int'(cnt_q) == BLINK_PERIOD - 1) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Stage 1: clamp the row, split it into block row / line, capture cell attributes.
    always_comb begin
        valid1_d  = enabled;
        fg1_d     = fg1_q;
        bg1_d     = bg1_q;
        blink1_d  = blink1_q;
        invert1_d = invert1_q;
        mosaic1_d = mosaic1_q;
        off1_d    = off1_q;
        bits1_d   = bits1_q;
        br1_d     = br1_q;
        line1_d   = line1_q;
        r_eff     = int'(char_row);
        if (r_eff > CHAR_HEIGHT - 1) r_eff = CHAR_HEIGHT - 1;
        if (enabled) begin
            fg1_d     = foreground;
            bg1_d     = background;
            blink1_d  = blink;
            invert1_d = invert;
            mosaic1_d = mosaic;
            off1_d    = phase_off;
            bits1_d   = gfx_bits;
            br1_d     = BR_W'(r_eff / BH);
            line1_d   = LN_W'(r_eff % BH);
        end
    end

    // Stage 2: expand the block row into pixels and resolve the final colour pair.
    always_comb begin
        enable_d = valid1_q;
        gfx_fg_d = gfx_fg_q;
        gfx_bg_d = gfx_bg_q;
        bitmap_d = bitmap_q;
        fg_sel   = invert1_q ? bg1_q : fg1_q;
        bg_sel   = invert1_q ? fg1_q : bg1_q;
        bit_idx  = 0;
        pix      = 1'b0;
        if (valid1_q) begin
            gfx_fg_d = (blink1_q && off1_q) ? bg_sel : fg_sel;
            gfx_bg_d = bg_sel;
            bitmap_d = '0;
            // Leftmost pixel first; each shift moves earlier pixels toward the MSB.
            for (int x = 0; x < CHAR_WIDTH; x++) begin
                bit_idx = NB - 1 - (int'(br1_q) * GRID_COLS + x / BW);
                pix     = |(bits1_q & (ONE_NB << bit_idx));
                if (mosaic1_q && (int'(line1_q) == 0 || int'(line1_q) == BH - 1 ||
                                  x % BW == 0 || x % BW == BW - 1)) begin
                    pix = 1'b0;
                end
                bitmap_d = {bitmap_d[CHAR_WIDTH-2:0], pix};
            end
        end
    end

    // State registers with synchronous reset flushing both stages and the blink count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            valid1_q  <= 1'b0;
            fg1_q     <= '0;
            bg1_q     <= '0;
            blink1_q  <= 1'b0;
            invert1_q <= 1'b0;
            mosaic1_q <= 1'b0;
            off1_q    <= 1'b0;
            bits1_q   <= '0;
            br1_q     <= '0;
            line1_q   <= '0;
            enable_q  <= 1'b0;
            gfx_fg_q  <= '0;
            gfx_bg_q  <= '0;
            bitmap_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            valid1_q  <= valid1_d;
            fg1_q     <= fg1_d;
            bg1_q     <= bg1_d;
            blink1_q  <= blink1_d;
            invert1_q <= invert1_d;
            mosaic1_q <= mosaic1_d;
            off1_q    <= off1_d;
            bits1_q   <= bits1_d;
            br1_q     <= br1_d;
            line1_q   <= line1_d;
            enable_q  <= enable_d;
            gfx_fg_q  <= gfx_fg_d;
            gfx_bg_q  <= gfx_bg_d;
            bitmap_q  <= bitmap_d;
        end
    end

    assign enable         = enable_q;
    assign gfx_foreground = gfx_fg_q;
    assign gfx_background = gfx_bg_q;
    assign gfx_bitmap     = bitmap_q;

endmodule
